// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the next-PC sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    DRAIN    = 3'd1,
    PUSH_PC  = 3'd2,
    PUSH_FLG = 3'd3,
    JUMP     = 3'd4
  } pc_state_e;

  localparam logic [31:0] PC_SEQ_RESET_VEC = 32'h20;
  localparam logic [31:0] PC_SEQ_INT_VEC   = 32'h0;
  localparam int unsigned PC_SEQ_PC_LIMIT  = 400;

endpackage

// File: rtl/pc_seq_fsm.sv
// Interrupt-entry sequencer: state register, drain counter, push handshake.
// Flag push is compiled in with PC_SEQ_FLAG_SAVE_EN.
module pc_seq_fsm
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_req,
  input  logic            stall,
  input  logic            ret_valid,
  input  logic            push_ack,
  input  logic [3:0]      flags_in,
  input  logic [PC_W-1:0] pc_cur,
  output pc_state_e       state,
  output logic            int_go,
  output logic            int_busy,
  output logic            flush,
  output logic            push_req,
  output logic [PC_W-1:0] push_data
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  pc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            int_pend_q, int_pend_d;
  logic            int_late_q, int_late_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] sav_pc_q, sav_pc_d;
`ifdef PC_SEQ_FLAG_SAVE_EN
  logic [3:0]      sav_flg_q, sav_flg_d;
`else
  logic            unused_flags;
  assign unused_flags = ^flags_in;
`endif

  // Requests arriving while busy go to int_late so the JUMP-edge clear
  // of int_pend does not lose them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_pend_d = int_pend_q;
    int_late_d = int_late_q;
    flush_d    = 1'b0;
    sav_pc_d   = sav_pc_q;
    int_go     = 1'b0;
`ifdef PC_SEQ_FLAG_SAVE_EN
    sav_flg_d  = sav_flg_q;
`endif
    if (state_q != RUN) int_late_d = int_late_q | int_req;
    case (state_q)
      RUN: begin
        int_pend_d = int_pend_q | int_req;
        if (!ret_valid && !stall && (int_pend_q || int_req)) begin
          int_go   = 1'b1;
          state_d  = DRAIN;
          flush_d  = 1'b1;
          sav_pc_d = pc_cur;
          cnt_d    = '0;
`ifdef PC_SEQ_FLAG_SAVE_EN
          sav_flg_d = flags_in;
`endif
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) state_d = PUSH_PC;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      PUSH_PC: begin
        if (push_ack) begin
`ifdef PC_SEQ_FLAG_SAVE_EN
          state_d = PUSH_FLG;
`else
          state_d = JUMP;
`endif
        end
      end
      PUSH_FLG: begin
        if (push_ack) state_d = JUMP;
      end
      JUMP: begin
        state_d    = RUN;
        int_pend_d = int_late_q | int_req;
        int_late_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
      int_late_q <= 1'b0;
      flush_q    <= 1'b0;
      sav_pc_q   <= '0;
`ifdef PC_SEQ_FLAG_SAVE_EN
      sav_flg_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      int_late_q <= int_late_d;
      flush_q    <= flush_d;
      sav_pc_q   <= sav_pc_d;
`ifdef PC_SEQ_FLAG_SAVE_EN
      sav_flg_q  <= sav_flg_d;
`endif
    end
  end

  always_comb begin
    push_data = '0;
    case (state_q)
      PUSH_PC:  push_data = sav_pc_q;
`ifdef PC_SEQ_FLAG_SAVE_EN
      PUSH_FLG: push_data = {{(PC_W-4){1'b0}}, sav_flg_q};
`endif
      default:  push_data = '0;
    endcase
  end

  assign state    = state_q;
  assign int_busy = (state_q != RUN);
  assign flush    = flush_q;
  assign push_req = (state_q == PUSH_PC) || (state_q == PUSH_FLG);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: pc register and priority mux around pc_seq_fsm.
// Optional flag save on interrupt entry: PC_SEQ_FLAG_SAVE_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(PC_SEQ_RESET_VEC),
  parameter logic [PC_W-1:0] INT_VEC   = PC_W'(PC_SEQ_INT_VEC),
  parameter int unsigned     PC_LIMIT  = PC_SEQ_PC_LIMIT,
  parameter int unsigned     DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_req,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_dst,
  input  logic            ret_valid,
  input  logic [PC_W-1:0] ret_addr,
  input  logic [3:0]      flags_in,
  input  logic            push_ack,
  output logic [PC_W-1:0] pc,
  output logic            int_busy,
  output logic            flush,
  output logic            push_req,
  output logic [PC_W-1:0] push_data
);

  pc_state_e       state;
  logic            int_go;
  logic [PC_W-1:0] pc_q, pc_d;

  pc_seq_fsm #(
    .PC_W      (PC_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .int_req   (int_req),
    .stall     (stall),
    .ret_valid (ret_valid),
    .push_ack  (push_ack),
    .flags_in  (flags_in),
    .pc_cur    (pc_q),
    .state     (state),
    .int_go    (int_go),
    .int_busy  (int_busy),
    .flush     (flush),
    .push_req  (push_req),
    .push_data (push_data)
  );

  always_comb begin
    pc_d = pc_q;
    case (state)
      RUN: begin
        if (ret_valid)                 pc_d = ret_addr;
        else if (stall || int_go)      pc_d = pc_q;
        else if (branch_taken)         pc_d = branch_dst;
        else if (pc_q < PC_W'(PC_LIMIT)) pc_d = pc_q + PC_W'(1);
      end
      JUMP:    pc_d = INT_VEC;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (either build of PC_SEQ_FLAG_SAVE_EN).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, int_req, stall, branch_taken, ret_valid, push_ack;
  logic [31:0] branch_dst, ret_addr, pc, push_data;
  logic [3:0]  flags_in;
  logic        int_busy, flush, push_req;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .int_req(int_req), .stall(stall),
    .branch_taken(branch_taken), .branch_dst(branch_dst),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .flags_in(flags_in),
    .push_ack(push_ack), .pc(pc), .int_busy(int_busy), .flush(flush),
    .push_req(push_req), .push_data(push_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic busy, input logic fl, input logic req);
    chk({tag, ".busy"}, {31'd0, int_busy}, {31'd0, busy});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    chk({tag, ".push_req"}, {31'd0, push_req}, {31'd0, req});
  endtask

  initial begin
    reset = 1'b1; int_req = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    ret_valid = 1'b0; push_ack = 1'b0; branch_dst = '0; ret_addr = '0;
    flags_in = 4'b1010;
    step(); step();
    chk("rst.pc", pc, 32'h20);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.push_data", push_data, 32'h0);

    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("free.pc", pc, 32'h20 + 32'(i));
      chk("free.busy", {31'd0, int_busy}, 32'd0);
    end

    stall = 1'b1;
    step(); chk("stall1.pc", pc, 32'h25);
    step(); chk("stall2.pc", pc, 32'h25);
    stall = 1'b0; branch_taken = 1'b1; branch_dst = 32'd100;
    step(); chk("branch.pc", pc, 32'd100);
    branch_dst = 32'd40;
    step(); chk("branch40.pc", pc, 32'd40);
    branch_taken = 1'b0;

    // Interrupt accepted on the edge that samples int_req at pc=40.
    int_req = 1'b1;
    step(); chk("acc.pc", pc, 32'd40); chk_ctl("acc", 1'b1, 1'b1, 1'b0);
    int_req = 1'b0;
`ifndef PC_SEQ_FLAG_SAVE_EN
    push_ack = 1'b1;
`endif
    step(); chk("drn1.pc", pc, 32'd40); chk_ctl("drn1", 1'b1, 1'b0, 1'b0);
    step(); chk("drn2.pc", pc, 32'd40);
    step(); chk("push.pc", pc, 32'd40); chk_ctl("push", 1'b1, 1'b0, 1'b1);
    chk("push.data", push_data, 32'd40);
`ifdef PC_SEQ_FLAG_SAVE_EN
    step(); chk("pwait1.req", {31'd0, push_req}, 32'd1); chk("pwait1.data", push_data, 32'd40);
    step(); chk("pwait2.req", {31'd0, push_req}, 32'd1); chk("pwait2.data", push_data, 32'd40);
    push_ack = 1'b1;
    step(); chk("flg.req", {31'd0, push_req}, 32'd1); chk("flg.data", push_data, 32'hA);
    push_ack = 1'b0;
    step(); chk("fwait1.data", push_data, 32'hA);
    step(); chk("fwait2.data", push_data, 32'hA);
    push_ack = 1'b1;
`endif
    step(); chk("jump.pc", pc, 32'd40); chk_ctl("jump", 1'b1, 1'b0, 1'b0);
    push_ack = 1'b0;
    step(); chk("vec.pc", pc, 32'h0); chk_ctl("vec", 1'b0, 1'b0, 1'b0);
    step(); chk("vec_inc.pc", pc, 32'h1);

    branch_taken = 1'b1; branch_dst = 32'd399;
    step(); chk("b399.pc", pc, 32'd399);
    branch_taken = 1'b0;
    step(); chk("lim.pc", pc, 32'd400);
    for (int i = 0; i < 3; i++) begin
      step(); chk("limhold.pc", pc, 32'd400);
    end

    // Return wins over a simultaneous request, which then stays pending.
    ret_valid = 1'b1; ret_addr = 32'd55; int_req = 1'b1;
    step(); chk("ret.pc", pc, 32'd55); chk_ctl("ret", 1'b0, 1'b0, 1'b0);
    ret_valid = 1'b0; int_req = 1'b0;
    step(); chk("pendacc.pc", pc, 32'd55); chk_ctl("pendacc", 1'b1, 1'b1, 1'b0);
    step(); step();
    step(); chk("push2.data", push_data, 32'd55); chk("push2.req", {31'd0, push_req}, 32'd1);
    int_req = 1'b1;
    step(); chk("push2hold.data", push_data, 32'd55);
    int_req = 1'b0; push_ack = 1'b1;
    for (int i = 0; i < 10 && int_busy; i++) step();
    chk("busy_timeout", {31'd0, int_busy}, 32'd0);
    chk("vec2.pc", pc, 32'h0);
    push_ack = 1'b0;
    step(); chk("late.pc", pc, 32'h0); chk_ctl("late", 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    step(); chk("rst2.pc", pc, 32'h20); chk_ctl("rst2", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); chk("post1.pc", pc, 32'h21); chk_ctl("post1", 1'b0, 1'b0, 1'b0);
    step(); chk("post2.pc", pc, 32'h22); chk_ctl("post2", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
